// File: rtl/lcd_reader.sv
// Reads 1..4 bytes from a character-LCD panel, packing them MSB-first into data_out.
// Optional busy-flag polling is enabled by defining LCD_READER_BUSYPOLL_EN.
module lcd_reader #(
  parameter int T_SETUP = 8,
  parameter int T_EN    = 24,
  parameter int T_HOLD  = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_rs,
  input  logic [2:0]  req_count,
  input  logic [7:0]  LCD_DATA,
  output logic        LCD_RW,
  output logic        LCD_RS,
  output logic        LCD_EN,
  output logic [31:0] data_out,
  output logic        valid,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_DONE} state_t;
  localparam int CW = 16;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [1:0]    r_last;
  logic          r_rw;
  logic          r_rs;
  logic          r_en;
  logic          r_valid;
  logic          r_busy;
  logic [31:0]   r_data;
`ifdef LCD_READER_BUSYPOLL_EN
  logic          r_poll;
  logic          r_timeout;
  logic [11:0]   r_polls;
`endif

  logic       w_cnt_zero;
  logic       w_more;
  logic [4:0] w_base;
  logic [1:0] w_last;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_more     = (r_idx != r_last);
  assign w_base     = 5'd31 - {r_idx, 3'b000};

  // 0 reads one byte, 5..7 read four.
  always_comb begin
    w_last = 2'd3;
    case (req_count)
      3'd0, 3'd1: w_last = 2'd0;
      3'd2:       w_last = 2'd1;
      3'd3:       w_last = 2'd2;
      default:    w_last = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_last  <= '0;
      r_rw    <= 1'b0;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
`ifdef LCD_READER_BUSYPOLL_EN
      r_poll    <= 1'b0;
      r_timeout <= 1'b0;
      r_polls   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state <= S_SETUP;
            r_rs    <= req_rs;
            r_rw    <= 1'b1;
            r_busy  <= 1'b1;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= w_last;
            r_cnt   <= CW'(T_SETUP - 1);
`ifdef LCD_READER_BUSYPOLL_EN
            r_poll    <= ~req_rs;
            r_timeout <= 1'b0;
            r_polls   <= '0;
            if (!req_rs) r_last <= 2'd0;
`endif
          end
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            r_state <= S_ENABLE;
            r_en    <= 1'b1;
            r_cnt   <= CW'(T_EN - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ENABLE: begin
          if (w_cnt_zero) begin
            r_data[w_base -: 8] <= LCD_DATA;
            r_en    <= 1'b0;
            r_state <= S_HOLD;
            r_cnt   <= CW'(T_HOLD - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else
`ifdef LCD_READER_BUSYPOLL_EN
          // In poll mode the status byte always lands in [31:24]; bit 31 is the busy flag.
          if (r_poll) begin
            if (r_data[31] && r_polls != 12'hFFF) begin
              r_polls <= r_polls + 12'd1;
              r_state <= S_SETUP;
              r_cnt   <= CW'(T_SETUP - 1);
            end else begin
              r_timeout <= r_data[31];
              r_state   <= S_DONE;
              r_valid   <= 1'b1;
              r_rw      <= 1'b0;
            end
          end else
`endif
          if (w_more) begin
            r_idx   <= r_idx + 2'd1;
            r_state <= S_SETUP;
            r_cnt   <= CW'(T_SETUP - 1);
          end else begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_rw    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign LCD_RW   = r_rw;
  assign LCD_RS   = r_rs;
  assign LCD_EN   = r_en;
  assign data_out = r_data;
  assign valid    = r_valid;
  assign busy     = r_busy;
`ifdef LCD_READER_BUSYPOLL_EN
  assign timeout  = r_timeout;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter T_SETUP, default 8: clk cycles from RS/RW valid to LCD_EN rise (tAS, 160 ns at 50 MHz).
REQ-002 Parameter T_EN, default 24: clk cycles LCD_EN held high per byte (PWEH, 480 ns).
REQ-003 Parameter T_HOLD, default 25: clk cycles LCD_EN held low after fall before next byte or DONE.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  read request, sampled only in IDLE.
REQ-007 req_rs  input  1  register select: 0 = busy flag/address, 1 = DDRAM/CGRAM data.
REQ-008 req_count  input  3  bytes to read, 1..4; 0 and 5..7 are treated as 1 and 4 respectively.
REQ-009 LCD_DATA  input  8  panel data bus as seen while the panel drives it.
REQ-010 LCD_RW  output  1  1 = read cycle in progress.
REQ-011 LCD_RS  output  1  registered copy of req_rs.
REQ-012 LCD_EN  output  1  panel enable strobe.
REQ-013 data_out  output  32  packed read bytes.
REQ-014 valid  output  1  one-cycle pulse, data_out complete.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 timeout  output  1  busy-poll exhaustion flag (Configuration).

Function
REQ-017 States: IDLE, SETUP, ENABLE, HOLD, DONE; one down-counter times every state.
REQ-018 IDLE: when req=1, latch req_rs and the clamped count, clear data_out, assert LCD_RW=1, go to SETUP.
REQ-019 SETUP lasts T_SETUP cycles, then ENABLE with LCD_EN=1.
REQ-020 ENABLE lasts T_EN cycles; LCD_DATA is sampled on its last cycle, then LCD_EN=0 and HOLD.
REQ-021 Byte packing is MSB-first: byte k (k=0 first) goes to data_out[31-8k -: 8]; unread bytes stay 0.
REQ-022 HOLD lasts T_HOLD cycles; then SETUP if bytes remain, else DONE.
REQ-023 DONE lasts one cycle: valid=1, LCD_RW=0, next state IDLE; data_out holds until the next accepted req.
REQ-024 req is ignored while busy=1; a req held high across DONE is accepted in the following IDLE cycle.
REQ-025 LCD_EN never rises unless LCD_RW=1 and LCD_RS have been stable for at least T_SETUP cycles.

Reset
REQ-026 rst_n=0 forces IDLE asynchronously: LCD_EN=0, LCD_RW=0, LCD_RS=0, data_out=0, valid=0, busy=0, timeout=0, counters=0.
REQ-027 Reset asserted mid-transfer aborts it with no valid pulse; LCD_EN falls in the same cycle.

Configuration
REQ-028 Macro LCD_READER_BUSYPOLL_EN defined: a req with req_rs=0 repeats single-byte reads until LCD_DATA[7]=0 or 4096 reads.
REQ-029 In poll mode valid pulses with the final status byte in data_out[31:24]; timeout=1 with valid on exhaustion, cleared at next accepted req.
REQ-030 Macro undefined: req_rs=0 performs a normal req_count-byte read; timeout is tied 0.

Verification
REQ-031 req=1, rs=1, count=4, LCD_DATA=" UIU" bytes per ENABLE -> data_out=0x20554955, valid once, transaction 4*(8+24+25)+2 cycles.
REQ-032 req, count=1, LCD_DATA=0x41 -> data_out=0x41000000; LCD_EN high exactly 24 cycles, RS/RW stable 8 cycles before rise.
REQ-033 rst_n low during second ENABLE of a 3-byte read -> all outputs 0 immediately, no valid; next req works normally.
REQ-034 New req during busy -> ignored; count=0 -> one byte read; count=7 -> four bytes read.
REQ-035 With LCD_READER_BUSYPOLL_EN: status 0x80 for 3 reads then 0x05 -> data_out=0x05000000, timeout=0; constant 0x80 -> timeout=1 after 4096 reads.
